// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared encodings for the AXI memory responder.
//   - AXI burst type and response encodings
//   - supported beat size (4-byte beats only)
//   - responder FSM state encoding
//   - burst_bad(): flags a burst that the memory cannot service
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  // Only FIXED and INCR bursts of full 32-bit beats are serviced.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != SIZE_WORD);
  endfunction

endpackage

// File: rtl/iob_axi_mem_ram.sv
// iob_axi_mem_ram: single-port synchronous RAM with byte write enables.
// A port access with no byte enable set is a read; its data appears on
// dout one cycle later and is held until the next read.
// Ports:
//   clk   in  clock
//   en    in  port access enable
//   we    in  DATA_W/8 byte write enables
//   addr  in  ADDR_W word address
//   din   in  DATA_W write data
//   dout  out DATA_W registered read data
module iob_axi_mem_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Byte-masked write or registered read on the single port
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we[b]) begin
          mem[addr][b*8 +: 8] <= din[b*8 +: 8];
        end
      end
      if (we == {(DATA_W/8){1'b0}}) begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave memory used as a DDR stand-in behind the
// L2 cache master. Serves FIXED/INCR bursts of 32-bit beats, one
// transaction at a time, with fair write/read arbitration. Bad burst
// type or size returns SLVERR (writes suppressed, reads return zero).
// Optional macro AXI_MEM_LATENCY_EN: delays the first rvalid of a read
// burst and the bvalid of a write burst by LAT cycles.
// Ports:
//   clk, rst (async, active-high)
//   AW: axi_awid/awaddr/awlen/awsize/awburst/awvalid in, axi_awready out
//   W : axi_wdata/wstrb/wlast/wvalid in, axi_wready out
//   B : axi_bid/bresp/bvalid out, axi_bready in
//   AR: axi_arid/araddr/arlen/arsize/arburst/arvalid in, axi_arready out
//   R : axi_rid/rdata/rresp/rlast/rvalid out, axi_rready in
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 14,
  parameter int AXI_DATA_W = 32,
  parameter int LAT        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_ID_W-1:0]     axi_awid,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [AXI_DATA_W-1:0]   axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [AXI_ID_W-1:0]     axi_bid,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [AXI_ID_W-1:0]     axi_arid,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [AXI_ID_W-1:0]     axi_rid,
  output logic [AXI_DATA_W-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic                    axi_rvalid,
  input  logic                    axi_rready
);

  localparam int WA_W = AXI_ADDR_W - 2;
  localparam logic [WA_W-1:0] WORD_ONE = {{(WA_W-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic                    prio_w;
  logic [AXI_ID_W-1:0]     id;
  logic [WA_W-1:0]         waddr, waddr_step;
  logic [7:0]              len, cnt;
  logic                    fixed, bad, last_err, rvalid, bvalid;
  logic                    aw_grant, ar_grant, w_hs, r_hs, b_hs, last_beat;
  logic                    rv_set, bv_set;
  logic                    ram_en;
  logic [AXI_DATA_W/8-1:0] ram_we;
  logic [WA_W-1:0]         ram_addr;
  logic [AXI_DATA_W-1:0]   ram_dout;
  logic                    unused_ok;

  assign unused_ok = ^{axi_awaddr[1:0], axi_araddr[1:0], 32'(LAT)};

  // prio_w breaks the tie only when both address channels request.
  assign aw_grant   = (state == ST_IDLE) && axi_awvalid && (!axi_arvalid || prio_w);
  assign ar_grant   = (state == ST_IDLE) && axi_arvalid && (!axi_awvalid || !prio_w);
  assign w_hs       = (state == ST_WDATA) && axi_wvalid;
  assign r_hs       = (state == ST_RDATA) && rvalid && axi_rready;
  assign b_hs       = (state == ST_WRESP) && bvalid && axi_bready;
  assign last_beat  = (cnt == len);
  // Word address is WA_W bits wide, so INCR wraps modulo the memory size.
  assign waddr_step = fixed ? waddr : (waddr + WORD_ONE);

`ifdef AXI_MEM_LATENCY_EN
  logic [31:0] lat_cnt;

  // Wait counter loaded when a read starts or the last write beat lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= 32'd0;
    end else if (ar_grant || (w_hs && axi_wlast)) begin
      lat_cnt <= 32'(LAT);
    end else if (lat_cnt != 32'd0) begin
      lat_cnt <= lat_cnt - 32'd1;
    end else begin
      lat_cnt <= lat_cnt;
    end
  end

  assign rv_set = (ar_grant && (LAT == 0)) || ((state == ST_RDATA) && (lat_cnt == 32'd1));
  assign bv_set = (w_hs && axi_wlast && (LAT == 0)) || ((state == ST_WRESP) && (lat_cnt == 32'd1));
`else
  assign rv_set = ar_grant;
  assign bv_set = w_hs && axi_wlast;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, channel readies and RAM port control
  always_comb begin
    state_nxt   = state;
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    ram_en      = 1'b0;
    ram_we      = {(AXI_DATA_W/8){1'b0}};
    ram_addr    = waddr;
    case (state)
      ST_IDLE: begin
        axi_awready = aw_grant;
        axi_arready = ar_grant;
        if (aw_grant) begin
          state_nxt = ST_WDATA;
        end else if (ar_grant) begin
          // First beat is read in the grant cycle.
          state_nxt = ST_RDATA;
          ram_en    = 1'b1;
          ram_addr  = axi_araddr[AXI_ADDR_W-1:2];
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WDATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          ram_en    = 1'b1;
          ram_we    = bad ? {(AXI_DATA_W/8){1'b0}} : axi_wstrb;
          state_nxt = axi_wlast ? ST_WRESP : ST_WDATA;
        end else begin
          state_nxt = ST_WDATA;
        end
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WRESP;
        end
      end
      ST_RDATA: begin
        if (r_hs && last_beat) begin
          state_nxt = ST_IDLE;
        end else if (r_hs) begin
          // Prefetch the next beat so back-to-back rready gives one beat per cycle.
          ram_en   = 1'b1;
          ram_addr = waddr_step;
        end else begin
          state_nxt = ST_RDATA;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Burst context, arbitration priority and response valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_w   <= 1'b1;
      id       <= {AXI_ID_W{1'b0}};
      waddr    <= {WA_W{1'b0}};
      len      <= 8'd0;
      cnt      <= 8'd0;
      fixed    <= 1'b0;
      bad      <= 1'b0;
      last_err <= 1'b0;
      rvalid   <= 1'b0;
      bvalid   <= 1'b0;
    end else begin
      if ((aw_grant || ar_grant) && axi_awvalid && axi_arvalid) begin
        prio_w <= !prio_w;
      end
      if (aw_grant) begin
        id       <= axi_awid;
        waddr    <= axi_awaddr[AXI_ADDR_W-1:2];
        len      <= axi_awlen;
        fixed    <= (axi_awburst == BURST_FIXED);
        bad      <= burst_bad(axi_awburst, axi_awsize);
        last_err <= 1'b0;
        cnt      <= 8'd0;
      end else if (ar_grant) begin
        id       <= axi_arid;
        waddr    <= axi_araddr[AXI_ADDR_W-1:2];
        len      <= axi_arlen;
        fixed    <= (axi_arburst == BURST_FIXED);
        bad      <= burst_bad(axi_arburst, axi_arsize);
        last_err <= 1'b0;
        cnt      <= 8'd0;
      end else if (w_hs) begin
        waddr <= waddr_step;
        cnt   <= cnt + 8'd1;
        // Covers both an early wlast and a missing wlast on beat len.
        if (last_beat != axi_wlast) begin
          last_err <= 1'b1;
        end
      end else if (r_hs && !last_beat) begin
        waddr <= waddr_step;
        cnt   <= cnt + 8'd1;
      end
      if (bv_set) begin
        bvalid <= 1'b1;
      end else if (b_hs) begin
        bvalid <= 1'b0;
      end
      if (rv_set) begin
        rvalid <= 1'b1;
      end else if (r_hs && last_beat) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign axi_bvalid = bvalid;
  assign axi_bid    = id;
  assign axi_bresp  = (bvalid && (bad || last_err)) ? RESP_SLVERR : RESP_OKAY;
  assign axi_rvalid = rvalid;
  assign axi_rid    = id;
  assign axi_rlast  = rvalid && last_beat;
  assign axi_rresp  = (rvalid && bad) ? RESP_SLVERR : RESP_OKAY;
  assign axi_rdata  = (rvalid && !bad) ? ram_dout : {AXI_DATA_W{1'b0}};

  iob_axi_mem_ram #(
    .ADDR_W(WA_W),
    .DATA_W(AXI_DATA_W)
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .addr(ram_addr),
    .din (axi_wdata),
    .dout(ram_dout)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default build).
module tb_axi_mem_responder;

  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  axi_awid;
  logic [13:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [0:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [0:0]  axi_arid;
  logic [13:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [0:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          both_hi = 0;
  logic [31:0] wbuf [0:15];
  logic [31:0] rbuf [0:15];
  logic [15:0] rlast_vec;
  logic [1:0]  rresp_b [0:15];
  logic [0:0]  rid_b [0:15];
  int          nrx;
  logic [1:0]  bresp_got;
  logic [0:0]  bid_got;
  logic        g;

  always @(negedge clk) begin
    if (axi_awready && axi_arready) both_hi++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic aw_set(input logic [0:0] id, input logic [13:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
    axi_awid = id; axi_awaddr = addr; axi_awlen = len;
    axi_awburst = burst; axi_awsize = size; axi_awvalid = 1'b1;
  endtask

  task automatic ar_set(input logic [0:0] id, input logic [13:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
    axi_arid = id; axi_araddr = addr; axi_arlen = len;
    axi_arburst = burst; axi_arsize = size; axi_arvalid = 1'b1;
  endtask

  task automatic w_phase(input int nbeats, input logic [3:0] strb);
    int n;
    for (int b = 0; b < nbeats; b++) begin
      axi_wdata = wbuf[b]; axi_wstrb = strb;
      axi_wlast = (b == nbeats - 1); axi_wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi_wready && n < 50) begin @(negedge clk); n++; end
      chk("wready", axi_wready, 1'b1);
      @(posedge clk); #1;
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bvalid", axi_bvalid, 1'b1);
    bresp_got = axi_bresp; bid_got = axi_bid;
    @(posedge clk); #1;
    axi_bready = 1'b0;
  endtask

  task automatic r_phase(input bit toggle);
    int  k;
    bit  done;
    nrx = 0; k = 0; done = 1'b0; rlast_vec = 16'h0000;
    while (!done && k < 200) begin
      axi_rready = toggle ? ~k[0] : 1'b1;
      @(negedge clk);
      if (axi_rvalid && axi_rready) begin
        rbuf[nrx] = axi_rdata; rlast_vec[nrx] = axi_rlast;
        rresp_b[nrx] = axi_rresp; rid_b[nrx] = axi_rid;
        nrx++;
        if (axi_rlast || nrx == 16) done = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    axi_rready = 1'b0;
    chk("r_done", done, 1'b1);
  endtask

  task automatic do_write(input logic [0:0] id, input logic [13:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int nbeats);
    int n;
    aw_set(id, addr, len, burst, 3'd2);
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 50) begin @(negedge clk); n++; end
    chk("awready", axi_awready, 1'b1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    w_phase(nbeats, strb);
  endtask

  task automatic ar_send(input logic [0:0] id, input logic [13:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n;
    ar_set(id, addr, len, burst, 3'd2);
    n = 0;
    @(negedge clk);
    while (!axi_arready && n < 50) begin @(negedge clk); n++; end
    chk("arready", axi_arready, 1'b1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [0:0] id, input logic [13:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    ar_send(id, addr, len, burst);
    r_phase(toggle);
  endtask

  // Both address channels valid together; returns 1 when the write won.
  task automatic arb_round(output logic won_w);
    wbuf[0] = 32'h1234_5678;
    aw_set(1'b0, 14'h200, 8'd0, INCR, 3'd2);
    ar_set(1'b0, 14'h010, 8'd0, INCR, 3'd2);
    @(negedge clk);
    won_w = axi_awready;
    chk("arb_one_grant", axi_awready ^ axi_arready, 1'b1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    if (won_w) w_phase(1, 4'hF);
    else r_phase(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    axi_awid = 1'b0; axi_awaddr = 14'h0; axi_awlen = 8'd0; axi_awsize = 3'd2;
    axi_awburst = INCR; axi_awvalid = 1'b0;
    axi_wdata = 32'h0; axi_wstrb = 4'h0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0;
    axi_arid = 1'b0; axi_araddr = 14'h0; axi_arlen = 8'd0; axi_arsize = 3'd2;
    axi_arburst = INCR; axi_arvalid = 1'b0; axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast}, 6'b0);
    chk("reset_data", {axi_rdata, axi_bresp, axi_rresp, axi_bid, axi_rid}, 38'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-beat round trip with ID echo
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(1'b1, 14'h010, 8'd0, INCR, 4'hF, 1);
    chk("single_bresp", bresp_got, 2'd0);
    chk("single_bid", bid_got, 1'b1);
    do_read(1'b1, 14'h010, 8'd0, INCR, 1'b0);
    chk("single_rdata", {nrx[3:0], rbuf[0]}, {4'd1, 32'hDEAD_BEEF});
    chk("single_rlast_resp_id", {rlast_vec[0], rresp_b[0], rid_b[0]}, {1'b1, 2'd0, 1'b1});

    // 8-beat INCR line fill, read back with rready toggling
    for (int i = 0; i < 8; i++) wbuf[i] = i;
    do_write(1'b0, 14'h100, 8'd7, INCR, 4'hF, 8);
    chk("burst_bresp", bresp_got, 2'd0);
    do_read(1'b0, 14'h100, 8'd7, INCR, 1'b1);
    chk("burst_count", nrx, 8);
    chk("burst_rlast", rlast_vec, 16'h0080);
    for (int i = 0; i < 8; i++) chk($sformatf("burst_beat%0d", i), rbuf[i], i);

    // Partial strobe: bytes 0 and 2 take 0xDD and 0xBB
    wbuf[0] = 32'h1122_3344;
    do_write(1'b0, 14'h020, 8'd0, INCR, 4'hF, 1);
    wbuf[0] = 32'hAABB_CCDD;
    do_write(1'b0, 14'h020, 8'd0, INCR, 4'h5, 1);
    do_read(1'b0, 14'h020, 8'd0, INCR, 1'b0);
    chk("strb_rdata", rbuf[0], 32'h11BB_33DD);

    // Simultaneous AW/AR: write, read, write
    arb_round(g); chk("arb_round1_w", g, 1'b1);
    arb_round(g); chk("arb_round2_r", g, 1'b0);
    chk("arb_round2_data", rbuf[0], 32'hDEAD_BEEF);
    arb_round(g); chk("arb_round3_w", g, 1'b1);
    chk("arb_never_both", both_hi, 0);

    // WRAP write is rejected and leaves memory untouched
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    do_write(1'b0, 14'h040, 8'd3, INCR, 4'hF, 4);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hFFFF_FF00 + i;
    do_write(1'b0, 14'h040, 8'd3, WRAP, 4'hF, 4);
    chk("wrap_bresp", bresp_got, 2'd2);
    do_read(1'b0, 14'h040, 8'd3, INCR, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_old%0d", i), rbuf[i], 32'hA0 + i);
    // WRAP read returns zero data with SLVERR
    do_read(1'b0, 14'h040, 8'd0, WRAP, 1'b0);
    chk("wrap_read", {rbuf[0], rresp_b[0], rlast_vec[0]}, {32'h0, 2'd2, 1'b1});

    // Early wlast: SLVERR, but the beats still land
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    do_write(1'b0, 14'h060, 8'd3, INCR, 4'hF, 2);
    chk("early_wlast_bresp", bresp_got, 2'd2);
    do_read(1'b0, 14'h060, 8'd1, INCR, 1'b0);
    chk("early_wlast_data", {rbuf[0], rbuf[1]}, {32'h55, 32'h66});

    // FIXED read repeats the same word
    do_read(1'b0, 14'h010, 8'd1, FIXED, 1'b0);
    chk("fixed_read", {rbuf[0], rbuf[1], rlast_vec[1:0]}, {32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10});

    // Reset while beat 3 of a read burst is presented
    ar_send(1'b0, 14'h100, 8'd7, INCR);
    axi_rready = 1'b1; nrx = 0;
    for (int k = 0; k < 50 && nrx < 3; k++) begin
      @(negedge clk);
      if (axi_rvalid) nrx++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_pre_beat3", {axi_rvalid, axi_rdata}, {1'b1, 32'd3});
    rst = 1'b1;
    #1;
    chk("rst_mid_burst", {axi_rvalid, axi_rlast, axi_arready, axi_awready}, 4'b0);
    @(posedge clk); #1;
    rst = 1'b0; axi_rready = 1'b0;
    do_read(1'b1, 14'h010, 8'd0, INCR, 1'b0);
    chk("after_rst_read", {rbuf[0], rlast_vec[0]}, {32'hDEAD_BEEF, 1'b1});

    // INCR read from the last word wraps to word 0
    wbuf[0] = 32'hCAFE_F00D;
    do_write(1'b0, 14'h3FFC, 8'd0, INCR, 4'hF, 1);
    wbuf[0] = 32'h0BAD_C0DE;
    do_write(1'b0, 14'h0000, 8'd0, INCR, 4'hF, 1);
    do_read(1'b0, 14'h3FFC, 8'd1, INCR, 1'b0);
    chk("addr_wrap", {rbuf[0], rbuf[1]}, {32'hCAFE_F00D, 32'h0BAD_C0DE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
